uart_tx_sequencer: RTL and testbench

Controller that sequences one UART transmit frame: start, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits. It has an internal baud divider and a valid/ready byte interface. The FSM uses the PHY states Idle, Start, Data, Parity, Stop1 and Stop2. It sits between the UART TX FIFO (upstream) and the serial pin, and its frame format is configured by the UART control registers.

---
 rtl/uart_tx_sequencer.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: sends one UART frame per accepted byte.
// Frame: start bit (0), DATA_BITS data bits LSB-first, optional parity bit,
// then one or two stop bits (1). Every bit lasts div+1 clock cycles.
//
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous, active-high reset
//   div_i     bit period minus one, in clock cycles (latched on accept)
//   parity_i  00 none, 01 even, 10 odd, 11 none (latched on accept)
//   nstop_i   0 one stop bit, 1 two stop bits (latched on accept)
//   data_i    byte to send (latched on accept)
//   valid_i   data_i is valid; accepted on an edge where ready_o is high
//   ready_o   sequencer is idle and can take a byte
//   txd_o     serial line, idle high
//   busy_o    frame in progress
//   done_o    one-cycle pulse in the first idle cycle after a frame
module uart_tx_sequencer #(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [1:0]           parity_i,
    input  logic                 nstop_i,
    input  logic [7:0]           data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 txd_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        Idle,
        Start,
        Data,
        Parity,
        Stop1,
        Stop2
    } stateT;

    stateT                stateQ, stateD;
    logic [DIV_WIDTH-1:0] cntQ, cntD;
    logic [DIV_WIDTH-1:0] divQ, divD;
    logic [2:0]           bitIdxQ, bitIdxD;
    logic [7:0]           dataQ, dataD;
    logic                 parEnQ, parEnD;
    logic                 parOddQ, parOddD;
    logic                 nstopQ, nstopD;
    logic                 txdD, readyD, busyD, doneD;
    logic                 bitEnd;

    assign bitEnd = (cntQ == '0);

    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        divD    = divQ;
        bitIdxD = bitIdxQ;
        dataD   = dataQ;
        parEnD  = parEnQ;
        parOddD = parOddQ;
        nstopD  = nstopQ;
        doneD   = 1'b0;

        // Count down inside a bit; each state transition below reloads divQ.
        if (stateQ != Idle && !bitEnd) begin
            cntD = cntQ - 1'b1;
        end

        unique case (stateQ)
            Idle: begin
                // ready_o is high exactly when the registered state is Idle.
                if (valid_i) begin
                    stateD  = Start;
                    cntD    = div_i;
                    divD    = div_i;
                    dataD   = data_i;
                    parEnD  = parity_i[0] ^ parity_i[1];
                    parOddD = (parity_i == 2'b10);
                    nstopD  = nstop_i;
                end
            end
            Start: begin
                if (bitEnd) begin
                    stateD  = Data;
                    cntD    = divQ;
                    bitIdxD = '0;
                end
            end
            Data: begin
                if (bitEnd) begin
                    cntD = divQ;
                    if (bitIdxQ == LastBit) begin
                        stateD = parEnQ ? Parity : Stop1;
                    end else begin
                        bitIdxD = bitIdxQ + 3'd1;
                    end
                end
            end
            Parity: begin
                if (bitEnd) begin
                    stateD = Stop1;
                    cntD   = divQ;
                end
            end
            Stop1: begin
                if (bitEnd) begin
                    cntD = divQ;
                    if (nstopQ) begin
                        stateD = Stop2;
                    end else begin
                        stateD = Idle;
                        doneD  = 1'b1;
                    end
                end
            end
            Stop2: begin
                if (bitEnd) begin
                    stateD = Idle;
                    doneD  = 1'b1;
                end
            end
            default: begin
                stateD = Idle;
            end
        endcase

        // Outputs are registered: decode them from the next state.
        unique case (stateD)
            Start:   txdD = 1'b0;
            Data:    txdD = dataQ[bitIdxD];
            Parity:  txdD = (^dataQ) ^ parOddQ;
            default: txdD = 1'b1;
        endcase
        readyD = (stateD == Idle);
        busyD  = (stateD != Idle);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateQ  <= Idle;
            cntQ    <= '0;
            divQ    <= '0;
            bitIdxQ <= '0;
            dataQ   <= '0;
            parEnQ  <= 1'b0;
            parOddQ <= 1'b0;
            nstopQ  <= 1'b0;
            txd_o   <= 1'b1;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            divQ    <= divD;
            bitIdxQ <= bitIdxD;
            dataQ   <= dataD;
            parEnQ  <= parEnD;
            parOddQ <= parOddD;
            nstopQ  <= nstopD;
            txd_o   <= txdD;
            ready_o <= readyD;
            busy_o  <= busyD;
            done_o  <= doneD;
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
module tb_uart_tx_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] divI;
    logic [1:0]  parityI;
    logic        nstopI;
    logic [7:0]  dataI;
    logic        validI;
    logic        readyO, txdO, busyO, doneO;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    uart_tx_sequencer #(.DIV_WIDTH(16), .DATA_BITS(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .div_i   (divI),
        .parity_i(parityI),
        .nstop_i (nstopI),
        .data_i  (dataI),
        .valid_i (validI),
        .ready_o (readyO),
        .txd_o   (txdO),
        .busy_o  (busyO),
        .done_o  (doneO)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue entry per clock cycle of line level.
    typedef bit bitQT[$];

    function automatic bitQT buildFrame(input logic [7:0] d, input int div, input logic [1:0] par,
                                        input logic ns);
        bitQT q;
        bit   b[$];
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        if (par == 2'b01 || par == 2'b10) b.push_back((^d) ^ (par == 2'b10));
        b.push_back(1'b1);
        if (ns) b.push_back(1'b1);
        foreach (b[i]) for (int k = 0; k <= div; k++) q.push_back(b[i]);
        return q;
    endfunction

    bitQT expQ;
    bit   expDone;
    bit   acceptSeen;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            expQ.delete();
            expDone    = 1'b0;
            acceptSeen = 1'b0;
        end else begin
            expDone    = 1'b0;
            acceptSeen = 1'b0;
            if (expQ.size() > 0) begin
                void'(expQ.pop_front());
                if (expQ.size() == 0) expDone = 1'b1;
            end else if (validI) begin
                expQ       = buildFrame(dataI, int'(divI), parityI, nstopI);
                acceptSeen = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (expQ.size() > 0) begin
            check("txd", 32'(txdO), 32'(expQ[0]));
            check("ready", 32'(readyO), 0);
            check("busy", 32'(busyO), 1);
            check("done", 32'(doneO), 0);
        end else begin
            check("txd", 32'(txdO), 1);
            check("ready", 32'(readyO), 1);
            check("busy", 32'(busyO), 0);
            check("done", 32'(doneO), 32'(expDone));
        end
    end

    // Sends one byte from an idle negedge; returns accept-to-done latency and per-cycle txd.
    task automatic sendFrame(input logic [7:0] d, input int div, input logic [1:0] par,
                             input logic ns, output int lat, output logic [255:0] samp);
        dataI   = d;
        divI    = 16'(div);
        parityI = par;
        nstopI  = ns;
        validI  = 1'b1;
        lat     = -1;
        samp    = '0;
        @(negedge clock);
        validI = 1'b0;
        for (int i = 1; i <= 250; i++) begin
            if (doneO) begin
                lat = i - 1;
                break;
            end
            samp[i-1] = txdO;
            @(negedge clock);
        end
    endtask

    initial begin
        int          lat;
        int          n;
        int          ones;
        logic [255:0] samp;
        logic [9:0]  seq;
        bitQT        pin;
        bit          ok;

        reset   = 1'b1;
        validI  = 1'b0;
        divI    = '0;
        parityI = '0;
        nstopI  = 1'b0;
        dataI   = '0;
        repeat (3) @(negedge clock);
        check("rst_txd", 32'(txdO), 1);
        check("rst_ready", 32'(readyO), 1);
        check("rst_busy", 32'(busyO), 0);
        check("rst_done", 32'(doneO), 0);
        reset = 1'b0;
        @(negedge clock);

        // Pin the model against hand-computed values.
        pin = buildFrame(8'hA5, 3, 2'b00, 1'b0); check("model_len_a5", pin.size(), 40);
        pin = buildFrame(8'hA5, 3, 2'b01, 1'b0); check("model_len_par", pin.size(), 44);
        pin = buildFrame(8'hFF, 1, 2'b00, 1'b1); check("model_len_2stop", pin.size(), 22);
        pin = buildFrame(8'hA5, 0, 2'b01, 1'b0); check("model_even_a5", 32'(pin[9]), 0);
        pin = buildFrame(8'hA5, 0, 2'b10, 1'b0); check("model_odd_a5", 32'(pin[9]), 1);
        pin = buildFrame(8'h07, 0, 2'b01, 1'b0); check("model_even_07", 32'(pin[9]), 1);
        pin = buildFrame(8'h00, 0, 2'b11, 1'b0); check("model_len_par11", pin.size(), 10);

        // 0xA5, div=3, no parity, one stop.
        sendFrame(8'hA5, 3, 2'b00, 1'b0, lat, samp);
        check("a5_latency", lat, 40);
        for (int k = 0; k < 10; k++) seq[k] = samp[k*4];
        check("a5_bits", 32'(seq), 32'h34A);

        sendFrame(8'hA5, 3, 2'b01, 1'b0, lat, samp);
        check("a5_even_latency", lat, 44);
        check("a5_even_bit", 32'(samp[36]), 0);
        sendFrame(8'hA5, 3, 2'b10, 1'b0, lat, samp);
        check("a5_odd_bit", 32'(samp[36]), 1);
        sendFrame(8'h07, 3, 2'b01, 1'b0, lat, samp);
        check("07_even_bit", 32'(samp[36]), 1);

        // 0xFF, div=1, two stop bits.
        sendFrame(8'hFF, 1, 2'b00, 1'b1, lat, samp);
        check("ff_latency", lat, 22);
        ones = 0;
        for (int i = 0; i < 22; i++) ones += int'(samp[i]);
        check("ff_start", 32'({samp[1], samp[0]}), 0);
        check("ff_ones", ones, 20);

        sendFrame(8'h5A, 0, 2'b11, 1'b0, lat, samp);
        check("par11_latency", lat, 10);

        // Back-to-back with valid held, div changed mid-frame.
        dataI = 8'h55; divI = 0; parityI = 2'b00; nstopI = 1'b0; validI = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            ok = acceptSeen;
        end
        check("b2b_accept1", 32'(ok), 1);
        dataI = 8'h0F;
        n = 1;
        repeat (3) begin @(negedge clock); n++; end
        divI = 16'd7;
        repeat (3) begin @(negedge clock); n++; end
        divI = 16'd0;
        while (!doneO && n < 100) begin @(negedge clock); n++; end
        check("b2b_latency1", n, 11);
        check("b2b_gap_done", 32'(doneO), 1);
        check("b2b_gap_ready", 32'(readyO), 1);
        @(negedge clock);
        check("b2b_accept2", 32'(acceptSeen), 1);
        check("b2b_start2", 32'(txdO), 0);
        validI = 1'b0;
        n = 1;
        while (!doneO && n < 100) begin @(negedge clock); n++; end
        check("b2b_latency2", n, 11);

        // Reset during data bit 4 of 0x3C, div=2.
        dataI = 8'h3C; divI = 2; parityI = 2'b00; nstopI = 1'b0; validI = 1'b1;
        @(negedge clock);
        validI = 1'b0;
        repeat (15) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_txd", 32'(txdO), 1);
        check("abort_ready", 32'(readyO), 1);
        check("abort_busy", 32'(busyO), 0);
        check("abort_done", 32'(doneO), 0);
        dataI = 8'h99; validI = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_no_accept", 32'(busyO), 0);
        validI = 1'b0;
        reset  = 1'b0;
        @(negedge clock);
        sendFrame(8'h81, 2, 2'b00, 1'b0, lat, samp);
        check("after_rst_latency", lat, 30);
        check("after_rst_bit0", 32'(samp[3]), 1);

        // Randomized frames with config scribbled mid-frame.
        for (int f = 0; f < 60; f++) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            dataI   = 8'($urandom);
            divI    = 16'($urandom_range(0, 4));
            parityI = 2'($urandom);
            nstopI  = 1'($urandom);
            validI  = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clock);
                ok = acceptSeen;
            end
            if (!ok) check("rand_accept_timeout", 0, 1);
            validI = 1'b0;
            for (int i = 0; i < int'($urandom_range(0, 40)); i++) begin
                dataI   = 8'($urandom);
                divI    = 16'($urandom_range(0, 7));
                parityI = 2'($urandom);
                nstopI  = 1'($urandom);
                @(negedge clock);
            end
        end
        n = 0;
        while (expQ.size() > 0 && n < 200) begin @(negedge clock); n++; end
        check("final_idle", 32'(expQ.size()), 0);
        repeat (2) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
